spi_counter_rx: RTL and testbench

SPI_COUNTER_RX -- requirements
Module: spi_counter_rx

---
 rtl/spi_counter_pkg.sv | 32 +++
 rtl/spi_sync_edge.sv | 44 ++++
 rtl/spi_counter_rx.sv | 203 ++++++++++++++++++++
 tb/tb_spi_counter_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_counter_pkg.sv
// Shared definitions for the SPI counter link (receiver here, master side later).
// Holds the FSM state encoding, frame geometry constants and the frame payload layout.
package spi_counter_pkg;

  localparam int unsigned FRAME_BYTES = 2;
  localparam int unsigned VALUE_W     = 14;
  localparam int unsigned HI_PAD_W    = 2;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned FRAME_W     = FRAME_BYTES * BYTE_W;
  localparam int unsigned BIT_CNT_W   = 3;
  localparam int unsigned STATE_W     = 2;

  // Receiver FSM; encoding is visible on o_state
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_BYTE_HI = 2'd1,
    ST_BYTE_LO = 2'd2
  } state_e;

  // One received frame: the top pad bits must be zero for the value to be accepted
  typedef struct packed {
    logic [HI_PAD_W-1:0] pad;
    logic [VALUE_W-1:0]  value;
  } frame_t;

  // Reassemble the two received bytes into the frame payload
  function automatic frame_t frame_from_bytes(input logic [BYTE_W-1:0] hi,
                                              input logic [BYTE_W-1:0] lo);
    return frame_t'({hi, lo});
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous input.
// Ports:
//   clk, reset   - system clock, async active-low reset
//   d            - asynchronous input
//   level        - synchronized level (last synchronizer flop)
//   rise, fall   - one-cycle strobes when the synchronized level changes
// SYNC_STAGES is intended to be 2 or 3; RST_VAL is the idle level of the input.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  // Shift chain plus one extra delayed copy used as the edge reference
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Both terms come straight from flops, so the strobes are glitch-free
  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave that receives 16-bit frames {2'b00, value[13:0]} MSB first.
// Accepted frames update o_value; frames with non-zero pad bits or cut short by
// ss rising are discarded with an o_frame_err pulse. During the high byte the
// slave shifts back the 8-bit count of accepted frames, then zeros.
// Ports:
//   clk, reset   - system clock, async active-low reset
//   sclk, mosi   - SPI clock/data from the master (asynchronous to clk)
//   ss           - slave select, active low
//   miso         - SPI data to the master (0 while ss is high)
//   o_value      - last accepted 14-bit value
//   o_valid      - one-cycle pulse when o_value updates
//   o_frame_err  - one-cycle pulse when a frame is discarded
//   o_state      - current FSM state (debug)
module spi_counter_rx
  import spi_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               ss,
  output logic               miso,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic [STATE_W-1:0] o_state
);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic sclk_rise, sclk_fall, unused_sclk_level;
  logic mosi_level, unused_mosi_rise, unused_mosi_fall;
  logic ss_level, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .d     (sclk),
    .level (unused_sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .d     (mosi),
    .level (mosi_level),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk   (clk),
    .reset (reset),
    .d     (ss),
    .level (ss_level),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]    rx_q, rx_d;
  logic [BYTE_W-1:0]    hi_q, hi_d;
  logic [BYTE_W-1:0]    tx_q, tx_d;
  logic [BYTE_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                 miso_q, miso_d;
  logic [VALUE_W-1:0]   value_q, value_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  logic [BYTE_W-1:0]    rx_next_c;
  logic                 byte_done_c;
  frame_t               frame_c;

  // Next byte contents and completion of the current byte on this sclk rise
  always_comb begin
    rx_next_c   = {rx_q[BYTE_W-2:0], mosi_level};
    byte_done_c = sclk_rise && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
    frame_c     = frame_from_bytes(hi_q, rx_next_c);
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    hi_d        = hi_q;
    tx_d        = tx_q;
    frame_cnt_d = frame_cnt_q;
    miso_d      = miso_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Extra sclk edges after a completed frame are ignored here
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d   = ST_BYTE_HI;
          bit_cnt_d = '0;
          tx_d      = frame_cnt_q;
          miso_d    = frame_cnt_q[BYTE_W-1];
        end
      end

      ST_BYTE_HI: begin
        if (sclk_rise) begin
          rx_d      = rx_next_c;
          bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
          if (byte_done_c) begin
            hi_d    = rx_next_c;
            state_d = ST_BYTE_LO;
          end
        end
        // The eighth fall lands in BYTE_LO, so only bits 6..0 are shifted here
        if (sclk_fall) begin
          tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
          miso_d = tx_q[BYTE_W-2];
        end
        if (ss_rise) begin
          state_d = ST_IDLE;
          ferr_d  = 1'b1;
        end
      end

      ST_BYTE_LO: begin
        if (sclk_fall) begin
          miso_d = 1'b0;
        end
        if (sclk_rise) begin
          rx_d      = rx_next_c;
          bit_cnt_d = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
        end
        // Frame completion wins over a simultaneous ss rise
        if (byte_done_c) begin
          state_d = ST_IDLE;
          if (frame_c.pad == '0) begin
            value_d     = frame_c.value;
            valid_d     = 1'b1;
            frame_cnt_d = BYTE_W'(frame_cnt_q + BYTE_W'(1));
          end else begin
            ferr_d = 1'b1;
          end
        end else if (ss_rise) begin
          state_d = ST_IDLE;
          ferr_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        miso_d  = 1'b0;
      end
    endcase

    // miso is held low whenever the slave is deselected
    if (ss_level) begin
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      hi_q        <= '0;
      tx_q        <= '0;
      frame_cnt_q <= '0;
      miso_q      <= 1'b0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      hi_q        <= hi_d;
      tx_q        <= tx_d;
      frame_cnt_q <= frame_cnt_d;
      miso_q      <= miso_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  assign miso        = miso_q;
  assign o_value     = value_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_spi_counter_rx.sv
// Directed + randomized bench for spi_counter_rx. A bit-banged SPI master drives
// frames at clk/8; a frame-level model predicts value, pulse counts and the
// count byte read back on miso.
module tb_spi_counter_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso;
  logic [13:0] o_value;
  logic        o_valid;
  logic        o_frame_err;
  logic [1:0]  o_state;

  spi_counter_rx #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .mosi        (mosi),
    .ss          (ss),
    .miso        (miso),
    .o_value     (o_value),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse observers
  int n_valid = 0;
  int n_ferr  = 0;
  int n_both  = 0;
  always @(negedge clk) begin
    if (o_valid) n_valid++;
    if (o_frame_err) n_ferr++;
    if (o_valid && o_frame_err) n_both++;
  end

  // Frame-level model
  logic [13:0] m_value = 14'h0;
  logic [7:0]  m_cnt   = 8'h0;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-banged mode-0 master; bits beyond 16 are random filler rises
  task automatic spi_frame(input logic [15:0] word, input int nbits,
                           input bit ss_with_last, output logic [15:0] rd);
    rd = 16'h0;
    @(negedge clk) ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? word[15 - i] : 1'($urandom);
      repeat (4) @(negedge clk);
      if (i < 16) rd[15 - i] = miso;
      sclk = 1'b1;
      if (ss_with_last && (i == nbits - 1)) ss = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ss   = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Run one frame and compare against the model
  task automatic run_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input int nbits, input bit ss_with_last);
    int v0, f0, exp_v, exp_f;
    logic [7:0]  start_cnt;
    logic [15:0] rd;
    v0 = n_valid;
    f0 = n_ferr;
    start_cnt = m_cnt;
    spi_frame({hi, lo}, nbits, ss_with_last, rd);
    if (nbits >= 16) begin
      if (hi[7:6] == 2'b00) begin
        m_value = {hi[5:0], lo};
        m_cnt   = m_cnt + 8'd1;
        exp_v = 1; exp_f = 0;
      end else begin
        exp_v = 0; exp_f = 1;
      end
    end else begin
      exp_v = 0; exp_f = 1;
    end
    chk({tag, "_value"}, 32'(o_value), 32'(m_value));
    chk({tag, "_valid"}, 32'(n_valid - v0), 32'(exp_v));
    chk({tag, "_ferr"},  32'(n_ferr - f0), 32'(exp_f));
    chk({tag, "_state"}, 32'(o_state), 32'd0);
    if (nbits >= 8)  chk({tag, "_miso_hi"}, 32'(rd[15:8]), 32'(start_cnt));
    if (nbits >= 16) chk({tag, "_miso_lo"}, 32'(rd[7:0]), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_value"}, 32'(o_value), 32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_ferr"},  32'(o_frame_err), 32'd0);
    chk({tag, "_miso"},  32'(miso), 32'd0);
    chk({tag, "_state"}, 32'(o_state), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_value = 14'h0;
    m_cnt   = 8'h0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  hi, lo;
    logic [15:0] rd;
    int          nb, v0, f0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Basic accepted frame, then count byte 1 seen on the next frame
    run_frame("f1234", 8'h12, 8'h34, 16, 1'b0);
    chk("f1234_lit", 32'(o_value), 32'h1234);

    // Non-zero pad bits: discarded, count unchanged (miso_hi of next frame = 1)
    run_frame("fC100", 8'hC1, 8'h00, 16, 1'b0);

    // Abort after 11 bits, then full 3F/FF
    run_frame("abort11", 8'hA5, 8'h5A, 11, 1'b0);
    run_frame("f3FFF", 8'h3F, 8'hFF, 16, 1'b0);
    chk("f3FFF_lit", 32'(o_value), 32'h3FFF);

    // ss rise in the same cycle as the 16th sclk rise
    run_frame("sametime", {2'b00, 6'($urandom)}, 8'($urandom), 16, 1'b1);

    // 20 rises in one ss window: extras ignored
    run_frame("rise20", {2'b00, 6'($urandom)}, 8'($urandom), 20, 1'b0);

    // Randomized mix
    for (int k = 0; k < 24; k++) begin
      hi = 8'($urandom);
      if ($urandom_range(3) != 0) hi[7:6] = 2'b00;
      lo = 8'($urandom);
      case ($urandom_range(5))
        0:       nb = $urandom_range(15, 1);
        1:       nb = $urandom_range(20, 17);
        default: nb = 16;
      endcase
      run_frame("rand", hi, lo, nb, 1'b0);
    end

    // Reset mid-frame after 5 bits: no pulses, reset values
    v0 = n_valid;
    f0 = n_ferr;
    @(negedge clk) ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    ss = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_value = 14'h0;
    m_cnt   = 8'h0;
    repeat (10) @(negedge clk);
    chk("midrst_nopulse_v", 32'(n_valid - v0), 32'd0);
    chk("midrst_nopulse_f", 32'(n_ferr - f0), 32'd0);
    check_reset_outputs("postrst");
    run_frame("f0001", 8'h00, 8'h01, 16, 1'b0);
    chk("f0001_lit", 32'(o_value), 32'h0001);

    // Count wrap: 256 accepted frames from reset, then frame 257 reads 8'h00
    do_reset();
    for (int k = 0; k < 256; k++) begin
      run_frame("wrap", {2'b00, 6'($urandom)}, 8'($urandom), 16, 1'b0);
    end
    spi_frame(16'h0000, 16, 1'b0, rd);
    chk("wrap_miso", 32'(rd[15:8]), 32'h00);

    chk("exclusive_pulses", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
